sfp_frame_checker: RTL and testbench

Receive-side test-traffic checker for the SFP PCS/PMA link test. It consumes 64-bit stream frames from the SFP RX path after they cross into the 100 MHz system domain, and checks each frame against the test-frame format the transmit-side generator emits: magic word, length, sequence number and payload pattern. It keeps good, bad and lost frame counters, derives a link-health flag, and drives the two status LEDs.

---
 rtl/sfp_frame_checker_pkg.sv | 36 +++
 rtl/sfp_frame_checker_if.sv | 19 +
 rtl/sfp_frame_checker_led_stretch.sv | 30 +++
 rtl/sfp_frame_checker.sv | 227 ++++++++++++++++++++++
 tb/tb_sfp_frame_checker.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sfp_frame_checker_pkg.sv
// Shared types and constants for the SFP receive-side test-frame checker.
// Optional build macro used by the checker: SFP_CHK_ERRLOG_EN.
package sfp_chk_pkg;

    // Header word 0 = {magic, length in words, sequence number}
    localparam logic [15:0] SFP_CHK_MAGIC  = 16'hA55A;
    localparam int unsigned HDR_MAGIC_LSB  = 48;
    localparam int unsigned HDR_LEN_LSB    = 32;
    localparam int unsigned HDR_SEQ_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DISCARD
    } chk_state_e;

    typedef enum logic [3:0] {
        ERR_NONE,
        ERR_MAGIC,
        ERR_LENGTH,
        ERR_SEQ,
        ERR_DATA,
        ERR_KEEP,
        ERR_TUSER,
        ERR_EARLY_LAST,
        ERR_LATE_LAST
    } err_code_e;

    // Unsigned add that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/sfp_frame_checker_if.sv
// 64-bit receive stream carrying test frames into the checker.
interface sfp_frame_checker_if;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tuser;

    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser,
        input  s_tready
    );

    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser,
        output s_tready
    );
endinterface

// File: rtl/sfp_frame_checker_led_stretch.sv
// Retriggerable pulse stretcher: a one-cycle trigger lights the LED for
// LED_STRETCH cycles; a new trigger restarts the full interval.
module sfp_chk_led_stretch #(
    parameter int unsigned LED_STRETCH = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    output logic led
);
    localparam int unsigned CW = $clog2(LED_STRETCH + 1);

    logic [CW-1:0] remain;

    // Load on trigger, count down while lit, registered LED output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= '0;
            led    <= 1'b0;
        end else if (trigger) begin
            remain <= CW'(LED_STRETCH - 1);
            led    <= 1'b1;
        end else if (remain != '0) begin
            remain <= remain - CW'(1);
            led    <= 1'b1;
        end else begin
            led    <= 1'b0;
        end
    end
endmodule

// File: rtl/sfp_frame_checker.sv
// Receive-side test-traffic checker: validates frame header, sequence and
// payload pattern, keeps good/bad/lost counters, derives link health and
// drives the status LEDs. Define SFP_CHK_ERRLOG_EN to add sticky
// first-error capture outputs.
module sfp_frame_checker
    import sfp_chk_pkg::*;
#(
    parameter int unsigned MAX_WORDS      = 256,
    parameter int unsigned GOOD_LOCK      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned LED_STRETCH    = 5_000_000
) (
    input  logic                 sysclk_100m,
    input  logic                 sys_reset_n,
    sfp_frame_checker_if.slave   rx,
    input  logic                 clear_cnt,
    output logic [31:0]          good_cnt,
    output logic [31:0]          bad_cnt,
    output logic [31:0]          lost_cnt,
    output logic                 link_ok,
    output logic [1:0]           sleds
`ifdef SFP_CHK_ERRLOG_EN
    ,
    output err_code_e            err_code,
    output logic [15:0]          err_word_idx,
    output logic [63:0]          err_expected,
    output logic [63:0]          err_received
`endif
);
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
    localparam int unsigned GW   = $clog2(GOOD_LOCK + 1);

    chk_state_e    state;
    logic          ready;
    logic [15:0]   word_idx;
    logic [15:0]   frame_len;
    logic [31:0]   frame_seq;
    logic [31:0]   expected_seq;
    logic          first_frame;
    logic [31:0]   lost_pend;
    logic [TW-1:0] timer;
    logic [GW-1:0] consec;
    logic          led_act;

    logic          beat;
    logic [15:0]   hdr_len;
    logic [31:0]   hdr_seq;
    logic [31:0]   seq_diff;
    logic          hdr_magic_ok;
    logic          hdr_len_ok;
    logic          seq_bad;
    logic [31:0]   hdr_lost;
    logic          last_idx;
    logic [63:0]   exp_word;
    err_code_e     err;
    logic          v_good;
    logic          v_bad;
    logic [31:0]   lost_inc;

    assign rx.s_tready  = ready;
    assign beat         = rx.s_tvalid & ready;
    assign hdr_len      = rx.s_tdata[HDR_LEN_LSB +: 16];
    assign hdr_seq      = rx.s_tdata[HDR_SEQ_LSB +: 32];
    assign seq_diff     = hdr_seq - expected_seq;
    assign hdr_magic_ok = rx.s_tdata[HDR_MAGIC_LSB +: 16] == SFP_CHK_MAGIC;
    assign hdr_len_ok   = (hdr_len >= 16'd2) && (hdr_len <= 16'(MAX_WORDS));
    assign seq_bad      = hdr_magic_ok && !first_frame && seq_diff[31];
    assign hdr_lost     = (hdr_magic_ok && !first_frame && !seq_diff[31]) ? seq_diff : '0;
    assign last_idx     = word_idx == (frame_len - 16'd1);
    assign sleds        = {led_act, link_ok};

    // Per-beat error decode and frame verdict
    always_comb begin
        err      = ERR_NONE;
        exp_word = '0;
        v_good   = 1'b0;
        v_bad    = 1'b0;
        lost_inc = '0;
        case (state)
            IDLE: begin
                exp_word = {SFP_CHK_MAGIC, hdr_len, expected_seq};
                if (!hdr_magic_ok)              err = ERR_MAGIC;
                else if (!hdr_len_ok)           err = ERR_LENGTH;
                else if (seq_bad)               err = ERR_SEQ;
                else if (rx.s_tkeep != 8'hFF)   err = ERR_KEEP;
                else if (rx.s_tuser)            err = ERR_TUSER;
                else if (rx.s_tlast)            err = ERR_EARLY_LAST;
                v_bad    = beat && (err != ERR_NONE);
                lost_inc = hdr_lost;
            end
            PAYLOAD: begin
                exp_word = {frame_seq, 16'h0000, word_idx};
                if (rx.s_tdata != exp_word)         err = ERR_DATA;
                else if (rx.s_tkeep != 8'hFF)       err = ERR_KEEP;
                else if (rx.s_tuser)                err = ERR_TUSER;
                else if (rx.s_tlast && !last_idx)   err = ERR_EARLY_LAST;
                else if (!rx.s_tlast && last_idx)   err = ERR_LATE_LAST;
                v_bad    = beat && (err != ERR_NONE);
                v_good   = beat && (err == ERR_NONE) && rx.s_tlast;
                lost_inc = lost_pend;
            end
            default: ;
        endcase
    end

    // Frame FSM with header capture and sequence tracking.
    // Sequence gaps are latched at the header and only added to lost_cnt
    // at the verdict, so all three counters move on the same cycle.
    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state        <= IDLE;
            ready        <= 1'b0;
            word_idx     <= '0;
            frame_len    <= '0;
            frame_seq    <= '0;
            expected_seq <= '0;
            first_frame  <= 1'b1;
            lost_pend    <= '0;
        end else begin
            ready <= 1'b1;
            if (beat) begin
                case (state)
                    IDLE: begin
                        if (hdr_magic_ok) begin
                            expected_seq <= hdr_seq + 32'd1;
                            first_frame  <= 1'b0;
                        end
                        frame_len <= hdr_len;
                        frame_seq <= hdr_seq;
                        word_idx  <= 16'd1;
                        lost_pend <= hdr_lost;
                        if (err == ERR_NONE)  state <= PAYLOAD;
                        else if (!rx.s_tlast) state <= DISCARD;
                    end
                    PAYLOAD: begin
                        if (err != ERR_NONE)  state    <= rx.s_tlast ? IDLE : DISCARD;
                        else if (rx.s_tlast)  state    <= IDLE;
                        else                  word_idx <= word_idx + 16'd1;
                    end
                    DISCARD: begin
                        if (rx.s_tlast) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Saturating frame counters; clear_cnt overrides any increment
    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
            lost_cnt <= '0;
        end else if (clear_cnt) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
            lost_cnt <= '0;
        end else begin
            if (v_good)         good_cnt <= sat_add(good_cnt, 32'd1);
            if (v_bad)          bad_cnt  <= sat_add(bad_cnt, 32'd1);
            if (v_good || v_bad) lost_cnt <= sat_add(lost_cnt, lost_inc);
        end
    end

    // Link health: lock after GOOD_LOCK consecutive good frames, drop on a
    // bad frame or when no frame completes within TIMEOUT_CYCLES
    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            timer   <= '0;
            consec  <= '0;
            link_ok <= 1'b0;
        end else begin
            if (v_good || v_bad)  timer <= '0;
            else if (timer != TLIM) timer <= timer + TW'(1);

            if (v_bad) begin
                consec  <= '0;
                link_ok <= 1'b0;
            end else if (v_good) begin
                if (consec != GW'(GOOD_LOCK)) consec <= consec + GW'(1);
                if (consec >= GW'(GOOD_LOCK - 1)) link_ok <= 1'b1;
            end else if (timer == TLIM) begin
                consec  <= '0;
                link_ok <= 1'b0;
            end
        end
    end

    sfp_chk_led_stretch #(
        .LED_STRETCH(LED_STRETCH)
    ) u_led_stretch (
        .clk     (sysclk_100m),
        .rst_n   (sys_reset_n),
        .trigger (v_good),
        .led     (led_act)
    );

`ifdef SFP_CHK_ERRLOG_EN
    logic err_held;

    // Sticky capture of the first bad verdict; re-armed by clear_cnt
    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            err_held     <= 1'b0;
            err_code     <= ERR_NONE;
            err_word_idx <= '0;
            err_expected <= '0;
            err_received <= '0;
        end else if (clear_cnt) begin
            err_held     <= 1'b0;
            err_code     <= ERR_NONE;
            err_word_idx <= '0;
            err_expected <= '0;
            err_received <= '0;
        end else if (v_bad && !err_held) begin
            err_held     <= 1'b1;
            err_code     <= err;
            err_word_idx <= (state == IDLE) ? 16'd0 : word_idx;
            err_expected <= exp_word;
            err_received <= rx.s_tdata;
        end
    end
`endif

endmodule

// File: tb/tb_sfp_frame_checker.sv
// Scoreboard bench for sfp_frame_checker: stimulus pushes hand-computed
// counter/link snapshots; a monitor pops one whenever the outputs move.
module tb_sfp_frame_checker;
    import sfp_chk_pkg::*;

    typedef struct packed {
        logic [31:0] good;
        logic [31:0] bad;
        logic [31:0] lost;
        logic        link;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_cnt = 1'b0;
    logic [31:0] good_cnt, bad_cnt, lost_cnt;
    logic        link_ok;
    logic [1:0]  sleds;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   mon_en = 1'b0;

    sfp_frame_checker_if bus ();

    sfp_frame_checker #(
        .MAX_WORDS      (256),
        .GOOD_LOCK      (4),
        .TIMEOUT_CYCLES (1000),
        .LED_STRETCH    (20)
    ) dut (
        .sysclk_100m (clk),
        .sys_reset_n (rst_n),
        .rx          (bus),
        .clear_cnt   (clear_cnt),
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt),
        .lost_cnt    (lost_cnt),
        .link_ok     (link_ok),
        .sleds       (sleds)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input logic [31:0] g, input logic [31:0] b,
                                input logic [31:0] l, input logic k);
        return '{good: g, bad: b, lost: l, link: k};
    endfunction

    function automatic logic [63:0] hdr(input logic [31:0] seq, input logic [15:0] len);
        return {16'hA55A, len, seq};
    endfunction

    function automatic logic [63:0] pw(input logic [31:0] seq, input logic [31:0] k);
        return {seq, k};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, want);
    endtask

    task automatic beat(input logic [63:0] d, input logic l, input logic [7:0] k = 8'hFF,
                        input logic u = 1'b0, input bit push = 1'b0, input exp_t e = '0);
        @(negedge clk);
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = d;
        bus.s_tkeep  = k;
        bus.s_tlast  = l;
        bus.s_tuser  = u;
        if (push) sb.push_back(e);
    endtask

    task automatic idle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.s_tvalid = 1'b0;
            bus.s_tlast  = 1'b0;
            bus.s_tuser  = 1'b0;
        end
    endtask

    task automatic good_frame(input logic [31:0] seq, input logic [15:0] len,
                              input bit push, input exp_t e);
        beat(hdr(seq, len), 1'b0);
        for (int unsigned k = 1; k < len; k++)
            beat(pw(seq, k), k == len - 1, 8'hFF, 1'b0, push && (k == len - 1), e);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        bus.s_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
    endtask

    // Monitor: any movement of counters/link pops the next expected snapshot
    initial begin
        logic [96:0] prev;
        logic [96:0] cur;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {good_cnt, bad_cnt, lost_cnt, link_ok};
            if (mon_en && cur !== prev) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_output: got good=%0d bad=%0d lost=%0d link=%0b, want no change",
                             good_cnt, bad_cnt, lost_cnt, link_ok);
                end else begin
                    e = sb.pop_front();
                    if (cur === e) n_pass++;
                    else $display("FAIL frame_verdict: got good=%0d bad=%0d lost=%0d link=%0b, want good=%0d bad=%0d lost=%0d link=%0b",
                                  good_cnt, bad_cnt, lost_cnt, link_ok, e.good, e.bad, e.lost, e.link);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want finished run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tkeep  = 8'hFF;
        bus.s_tlast  = 1'b0;
        bus.s_tuser  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_good", good_cnt, 0);
        check("rst_bad", bad_cnt, 0);
        check("rst_lost", lost_cnt, 0);
        check("rst_link", link_ok, 0);
        check("rst_sleds", sleds, 0);
        check("rst_tready", bus.s_tready, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("tready_up", bus.s_tready, 1);
        mon_en = 1'b1;

        // Ten clean back-to-back frames; link locks on the 4th
        for (int i = 0; i < 10; i++)
            good_frame(i, 4, 1'b1, ex(i + 1, 0, 0, i >= 3));
        idle(2);

        // Word 2 bit 0 flipped, three trailing beats before tlast
        beat(hdr(10, 4), 1'b0);
        beat(pw(10, 1), 1'b0);
        beat(pw(10, 2) ^ 64'h1, 1'b0, 8'hFF, 1'b0, 1'b1, ex(10, 1, 0, 0));
        beat(pw(10, 3), 1'b0);
        beat(pw(10, 4), 1'b0);
        beat(pw(10, 5), 1'b0);
        beat(pw(10, 6), 1'b1);
        idle(1);
        check("discard_to_idle", 64'(dut.state), 64'(IDLE));
        good_frame(11, 4, 1'b1, ex(11, 1, 0, 0));
        idle(2);

        // Sequence gap: 0, 1, 5
        do_reset();
        good_frame(0, 4, 1'b1, ex(1, 0, 0, 0));
        good_frame(1, 4, 1'b1, ex(2, 0, 0, 0));
        good_frame(5, 4, 1'b1, ex(3, 0, 3, 0));
        idle(1);

        // Length errors: L=1 with tlast, then L=300
        beat(hdr(6, 1), 1'b1, 8'hFF, 1'b0, 1'b1, ex(3, 1, 3, 0));
        idle(1);
        check("len1_idle", 64'(dut.state), 64'(IDLE));
        beat(hdr(7, 300), 1'b0, 8'hFF, 1'b0, 1'b1, ex(3, 2, 3, 0));
        idle(1);
        check("len300_discard", 64'(dut.state), 64'(DISCARD));
        beat(pw(7, 1), 1'b0);
        beat(pw(7, 2), 1'b1);
        idle(1);
        check("len300_idle", 64'(dut.state), 64'(IDLE));

        // Duplicate sequence number (expected 8, got 7)
        beat(hdr(7, 2), 1'b0, 8'hFF, 1'b0, 1'b1, ex(3, 3, 3, 0));
        beat(pw(7, 1), 1'b1);
        idle(1);
        good_frame(8, 2, 1'b1, ex(4, 3, 3, 0));
        idle(1);

        // Upstream error mid-frame, then bad keep together with early tlast
        beat(hdr(9, 3), 1'b0);
        beat(pw(9, 1), 1'b0, 8'hFF, 1'b1, 1'b1, ex(4, 4, 3, 0));
        beat(pw(9, 2), 1'b1);
        idle(1);
        beat(hdr(10, 3), 1'b0);
        beat(pw(10, 1), 1'b1, 8'h0F, 1'b0, 1'b1, ex(4, 5, 3, 0));
        idle(1);
        good_frame(11, 2, 1'b1, ex(5, 5, 3, 0));
        idle(2);

        // Saturation near the top of good_cnt
        do_reset();
        good_frame(0, 2, 1'b1, ex(1, 0, 0, 0));
        idle(2);
        mon_en = 1'b0;
        @(negedge clk);
        force dut.good_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.good_cnt;
        for (int i = 1; i <= 3; i++) begin
            good_frame(i, 2, 1'b0, '0);
            idle(1);
            check("good_saturate", good_cnt, 32'hFFFF_FFFF);
        end

        // clear_cnt on the same cycle as a good verdict
        beat(hdr(4, 2), 1'b0);
        beat(pw(4, 1), 1'b1);
        clear_cnt = 1'b1;
        idle(1);
        clear_cnt = 1'b0;
        check("clear_good", good_cnt, 0);
        check("clear_bad", bad_cnt, 0);
        check("clear_keeps_link", link_ok, 1);

        // Timeout: link_ok falls exactly 1000 cycles after the last verdict
        good_frame(5, 2, 1'b0, '0);
        idle(1);
        check("after_clear_good", good_cnt, 1);
        check("sleds_active", sleds, 2'b11);
        repeat (999) @(posedge clk);
        @(negedge clk);
        check("link_before_timeout", link_ok, 1);
        @(posedge clk);
        @(negedge clk);
        check("link_timeout", link_ok, 0);
        check("sleds_timeout", sleds, 2'b00);

        // Reset asserted mid-frame
        good_frame(6, 3, 1'b0, '0);
        idle(1);
        check("pre_reset_good", good_cnt, 2);
        beat(hdr(7, 4), 1'b0);
        beat(pw(7, 1), 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_good", good_cnt, 0);
        check("midrst_lost", lost_cnt, 0);
        check("midrst_link", link_ok, 0);
        check("midrst_sleds", sleds, 0);
        check("midrst_tready", bus.s_tready, 0);
        check("midrst_state", 64'(dut.state), 64'(IDLE));
        bus.s_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        good_frame(100, 3, 1'b1, ex(1, 0, 0, 0));
        idle(2);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
